// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding reg_file: owns the PC, registers the fetched word,
// redirects on taken jumps, holds on stall and stops on the halt word.
module fetch_unit #(
    parameter int unsigned        PC_W       = 8,
    parameter int unsigned        INSTR_W    = 9,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1ff,
    parameter int unsigned        CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    input  logic               stall,
    input  logic               branch_en,
    input  logic [7:0]         branch_base,
    input  logic [3:0]         branch_offs,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    instr_pc,
    output logic               halted,
    output logic [CNT_W-1:0]   icount
);

    localparam int unsigned BASE_W = 8;
    localparam int unsigned SUM_W  = BASE_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                instr_valid_q, instr_valid_d;
    logic [PC_W-1:0]     instr_pc_q, instr_pc_d;
    logic                halted_q, halted_d;
    logic [CNT_W-1:0]    icount_q, icount_d;
    logic [SUM_W-1:0]    br_sum_c;
    logic [PC_W-1:0]     br_target_c;

    // Jump target wraps modulo the PC range
    assign br_sum_c    = SUM_W'(branch_base) + SUM_W'(branch_offs);
    assign br_target_c = PC_W'(br_sum_c);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        instr_pc_d    = instr_pc_q;
        halted_d      = halted_q;
        icount_d      = icount_q;

        if (!stall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d       = ST_RUN;
                        pc_d          = start_pc;
                        instr_valid_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (branch_en) begin
                        // Word fetched this cycle is wrong-path: drop it, leave a bubble
                        pc_d          = br_target_c;
                        instr_valid_d = 1'b0;
                    end else begin
                        instr_d       = imem_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + PC_W'(1);
                        if (icount_q != '1) begin
                            icount_d = icount_q + CNT_W'(1);
                        end
                        if (imem_data == HALT_INSTR) begin
                            state_d = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b1;
                    if (start) begin
                        state_d  = ST_RUN;
                        pc_d     = start_pc;
                        halted_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= '0;
            halted_q      <= 1'b0;
            icount_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            instr_pc_q    <= instr_pc_d;
            halted_q      <= halted_d;
            icount_q      <= icount_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;
    assign icount      = icount_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected issues are queued as stimulus is driven
// and compared whenever the stage presents a newly issued instruction.
module tb_fetch_unit;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 9;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] word;
        logic [CNT_W-1:0]   cnt;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [PC_W-1:0]    start_pc;
    logic               stall;
    logic               branch_en;
    logic [7:0]         branch_base;
    logic [3:0]         branch_offs;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    instr_pc;
    logic               halted;
    logic [CNT_W-1:0]   icount;

    logic [INSTR_W-1:0] mem [256];
    exp_t               exp_q [$];
    logic [CNT_W-1:0]   exp_cnt;
    logic [PC_W-1:0]    mpc;
    logic [INSTR_W-1:0] held_instr;
    int unsigned        n_chk  = 0;
    int unsigned        n_pass = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_unit #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .HALT_INSTR(9'h1ff),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_pc   (start_pc),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_base(branch_base),
        .branch_offs(branch_offs),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_pc   (instr_pc),
        .halted     (halted),
        .icount     (icount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"},   32'(imem_addr),   32'h0);
        check({tag, "_instr"},  32'(instr),       32'h0);
        check({tag, "_valid"},  32'(instr_valid), 32'h0);
        check({tag, "_ipc"},    32'(instr_pc),    32'h0);
        check({tag, "_halted"}, 32'(halted),      32'h0);
        check({tag, "_icount"}, 32'(icount),      32'h0);
    endtask

    // Compare each new issue (valid after a non-stalled edge) against the queue head
    task automatic monitor();
        logic st;
        exp_t e;
        forever begin
            @(posedge clk);
            st = stall;
            @(negedge clk);
            if (instr_valid && !st && !reset) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_instr",  32'(instr),    32'(e.word));
                    check("sb_ipc",    32'(instr_pc), 32'(e.pc));
                    check("sb_icount", 32'(icount),   32'(e.cnt));
                end
            end
        end
    endtask

    // Queue n sequential issues from mpc, one per cycle
    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            if (exp_cnt != '1) exp_cnt = CNT_W'(exp_cnt + CNT_W'(1));
            exp_q.push_back('{pc: mpc, word: mem[mpc], cnt: exp_cnt});
            mpc = PC_W'(mpc + PC_W'(1));
            @(negedge clk);
        end
    endtask

    task automatic jump(input logic [7:0] base, input logic [3:0] offs);
        branch_en   = 1'b1;
        branch_base = base;
        branch_offs = offs;
        @(negedge clk);
        branch_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [PC_W-1:0] addr);
        start    = 1'b1;
        start_pc = addr;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = INSTR_W'(i) ^ 9'h055;
        mem[8'h10] = 9'h003;
        mem[8'h11] = 9'h01e;
        mem[8'h12] = 9'h02c;
        mem[8'h1f] = 9'h0ae;
        mem[8'h20] = 9'h1ff;
        mem[8'h40] = 9'h1ff;
        reset = 1'b1; start = 1'b0; start_pc = '0; stall = 1'b0;
        branch_en = 1'b0; branch_base = '0; branch_offs = '0;
        exp_cnt = '0; mpc = '0;
        fork monitor(); join_none

        repeat (2) @(negedge clk);
        check_reset("rst");
        reset = 1'b0;
        @(negedge clk);
        check("idle_addr", 32'(imem_addr), 32'h0);
        check("idle_valid", 32'(instr_valid), 32'h0);

        // T1: start at 0x10, one bubble then three sequential issues
        pulse_start(8'h10);
        check("t1_bubble", 32'(instr_valid), 32'h0);
        check("t1_addr", 32'(imem_addr), 32'h10);
        mpc = 8'h10;
        issue(3);
        check("t1_icount", 32'(icount), 32'd3);

        // T2: 0x41 + 7 -> 0x48, bubble holds instr and icount
        jump(8'h41, 4'h7);
        check("t2_addr", 32'(imem_addr), 32'h48);
        check("t2_bubble", 32'(instr_valid), 32'h0);
        check("t2_instr_hold", 32'(instr), 32'h02c);
        check("t2_icount", 32'(icount), 32'd3);
        mpc = 8'h48;
        issue(2);

        // T3: halt at 0x20, then restart at 0
        jump(8'h10, 4'hf);
        mpc = 8'h1f;
        issue(2);
        check("t3_not_yet_halted", 32'(halted), 32'h0);
        @(negedge clk);
        check("t3_halted", 32'(halted), 32'h1);
        check("t3_valid_off", 32'(instr_valid), 32'h0);
        check("t3_pc_frozen", 32'(imem_addr), 32'h21);
        @(negedge clk);
        check("t3_pc_still", 32'(imem_addr), 32'h21);
        check("t3_icount", 32'(icount), 32'(exp_cnt));
        pulse_start(8'h00);
        check("t3_resume_halted", 32'(halted), 32'h0);
        check("t3_resume_addr", 32'(imem_addr), 32'h00);
        mpc = 8'h00;
        issue(2);

        // T4: fetch across the PC wrap, then 0xfc + 8 -> 0x04
        jump(8'hf0, 4'he);
        check("t4_addr_fe", 32'(imem_addr), 32'hfe);
        mpc = 8'hfe;
        issue(3);
        check("t4_wrap_addr", 32'(imem_addr), 32'h01);
        jump(8'hfc, 4'h8);
        check("t4_jump_wrap", 32'(imem_addr), 32'h04);
        mpc = 8'h04;
        issue(1);

        // T5: stall with branch_en and start asserted freezes everything
        held_instr  = mem[8'h04];
        stall       = 1'b1;
        branch_en   = 1'b1;
        branch_base = 8'h30;
        branch_offs = 4'h2;
        start       = 1'b1;
        start_pc    = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_instr", 32'(instr), 32'(held_instr));
            check("t5_ipc", 32'(instr_pc), 32'h04);
            check("t5_valid", 32'(instr_valid), 32'h1);
            check("t5_addr", 32'(imem_addr), 32'h05);
            check("t5_icount", 32'(icount), 32'(exp_cnt));
        end
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        branch_en = 1'b0;
        check("t5_redirect", 32'(imem_addr), 32'h32);
        check("t5_bubble", 32'(instr_valid), 32'h0);
        mpc = 8'h32;
        issue(1);
        jump(8'h40, 4'h0);
        jump(8'h50, 4'h0);
        check("t5_flush_addr", 32'(imem_addr), 32'h50);
        check("t5_no_halt", 32'(halted), 32'h0);
        mpc = 8'h50;
        issue(2);
        check("t5_no_halt_later", 32'(halted), 32'h0);

        // T6: asynchronous reset mid-run
        #2 reset = 1'b1;
        #1 check_reset("t6_run_rst");
        exp_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        reset = 1'b0;
        pulse_start(8'h60);
        mpc = 8'h60;
        issue(1);
        stall = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset("t6_stall_rst");
        stall = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_idle_addr", 32'(imem_addr), 32'h0);
        check("t6_idle_valid", 32'(instr_valid), 32'h0);

        // Saturation: preload the counter near the top
        force dut.icount_q = 16'hfffe;
        #1 release dut.icount_q;
        exp_cnt = 16'hfffe;
        check("sat_preload", 32'(icount), 32'hfffe);
        @(negedge clk);
        pulse_start(8'h70);
        mpc = 8'h70;
        issue(3);
        check("sat_icount", 32'(icount), 32'hffff);
        #1 check("sb_drain", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
